// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Multi-cycle load/store unit between the execute stage and a
//               byte-enabled, word-wide data bus with wait states. Loads
//               return sign/zero-extended data. Stores return a completion.
//               Misaligned or illegal accesses are answered with an error
//               and never reach the bus.
// Option      : LSU_TIMEOUT_EN - when defined, an access that waits
//               TIMEOUT_CYCLES bus cycles without an ack is aborted with an
//               error response.
// Ports       : clk, rst_n          - clock (rising edge), async active-low reset
//               i_req_*             - request from core (valid/ready handshake)
//               o_rsp_*             - one-cycle response pulse, data and error
//               o_bus_*, i_bus_*    - data-memory bus (req held until ack)
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_be,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Out-of-range values leave the design functional but are not meaningful.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_bad
  end

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic        r_we;
  logic [29:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_illegal;
  logic        w_misalign;
  logic        w_req_err;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic        w_timeout;

  // --------------------------------------------------------------------------
  // Request decode: legality, alignment, store lane mapping
  // --------------------------------------------------------------------------
  always_comb begin
    // Stores allow only B/H/W; loads additionally allow BU/HU.
    w_illegal  = i_req_we ? (i_req_funct3[2] || (i_req_funct3[1:0] == 2'b11))
                          : ((i_req_funct3[1:0] == 2'b11) || (i_req_funct3 == 3'b110));
    w_misalign = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                 ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
    w_req_err  = w_illegal || w_misalign;

    w_be    = 4'b1111;
    w_wdata = 32'd0;
    if (i_req_we) begin
      case (i_req_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << i_req_addr[1:0];
          w_wdata = {4{i_req_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = i_req_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{i_req_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = i_req_wdata;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Load extraction from the returned bus word
  // --------------------------------------------------------------------------
  always_comb begin
    case (r_off)
      2'd0:    w_byte = i_bus_rdata[7:0];
      2'd1:    w_byte = i_bus_rdata[15:8];
      2'd2:    w_byte = i_bus_rdata[23:16];
      default: w_byte = i_bus_rdata[31:24];
    endcase
    w_half = r_off[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];

    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b010:  w_ext = i_bus_rdata;
      3'b100:  w_ext = {24'd0, w_byte};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = 32'd0;
    endcase
    if (r_we) begin
      w_ext = 32'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Optional bus wait timeout
  // --------------------------------------------------------------------------
`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_cnt;

  // r_cnt counts completed no-ack BUS cycles, so comparing against LIMIT-1
  // aborts at the end of the TIMEOUT_CYCLES-th wait cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
    end else if (r_state != S_BUS) begin
      r_cnt <= 16'd0;
    end else if (!i_bus_ack) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign w_timeout = (r_state == S_BUS) && (r_cnt == c_TIMEOUT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_next = w_req_err ? S_RESP : S_BUS;
        end
      end
      S_BUS: begin
        // An ack always wins over a simultaneous timeout.
        if (i_bus_ack || w_timeout) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Transaction datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_addr   <= 30'd0;
      r_be     <= 4'd0;
      r_wdata  <= 32'd0;
      r_funct3 <= 3'd0;
      r_off    <= 2'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && i_req_valid) begin
        r_we     <= i_req_we;
        r_addr   <= i_req_addr[31:2];
        r_be     <= w_be;
        r_wdata  <= w_wdata;
        r_funct3 <= i_req_funct3;
        r_off    <= i_req_addr[1:0];
        r_rdata  <= 32'd0;
        r_err    <= w_req_err;
      end else if (r_state == S_BUS) begin
        if (i_bus_ack) begin
          r_rdata <= w_ext;
          r_err   <= 1'b0;
        end else if (w_timeout) begin
          r_rdata <= 32'd0;
          r_err   <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (bus and response fields are zero outside their states)
  // --------------------------------------------------------------------------
  always_comb begin
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_rsp_rdata = 32'd0;
    o_rsp_err   = 1'b0;
    o_bus_req   = 1'b0;
    o_bus_we    = 1'b0;
    o_bus_addr  = 32'd0;
    o_bus_wdata = 32'd0;
    o_bus_be    = 4'd0;
    case (r_state)
      S_IDLE: o_req_ready = 1'b1;
      S_BUS: begin
        o_bus_req   = 1'b1;
        o_bus_we    = r_we;
        o_bus_addr  = {r_addr, 2'b00};
        o_bus_wdata = r_wdata;
        o_bus_be    = r_be;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_rdata = r_rdata;
        o_rsp_err   = r_err;
      end
      default: o_req_ready = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the core's execute stage and the data-memory bus. Accepts one load or store per request, using the ALU-computed address, rs2 store data and funct3. It drives a byte-enabled word bus that may insert wait states. It returns sign- or zero-extended load data, or a store completion, and flags misaligned or illegal accesses without touching the bus.

## Interface
- TIMEOUT_CYCLES, 255 — maximum bus wait cycles before abort (used only with LSU_TIMEOUT_EN); legal range 1..65535
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  LSU accepts a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  qualifies rsp_valid: misaligned, illegal funct3 or timeout
- bus_req  out  1  bus access pending
- bus_we  out  1  bus write
- bus_addr  out  32  word address, {req_addr[31:2], 2'b00}
- bus_wdata  out  32  lane-replicated write data
- bus_be  out  4  byte enables
- bus_ack  in  1  access complete; sampled only while bus_req = 1
- bus_rdata  in  32  read word, valid with bus_ack

## Operation
- FSM states:
  - IDLE: req_ready = 1.
  - BUS: bus_req = 1.
  - RESP: rsp_valid = 1.
- IDLE transitions, on req_valid:
  - Legal access → BUS; register addr, we, be, wdata, funct3 and addr[1:0].
  - Illegal or misaligned access → RESP with err = 1.
- Illegal access:
  - Loads: funct3 011, 110, 111.
  - Stores: funct3 other than 000–010.
- Misaligned access: H/HU with addr[0] = 1; W with addr[1:0] ≠ 0.
- BUS transitions:
  - bus_ack → RESP. Capture the extended read data for loads, 0 for stores.
  - No ack → remain in BUS.
- RESP → IDLE unconditionally.
- Store lane mapping:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111; wdata = wdata.
- Loads: be = 4'b1111.
- Load extraction: byte = bus_rdata[8*addr[1:0] +: 8]; half = bus_rdata[16*addr[1] +: 16]. B/H sign-extend, BU/HU zero-extend, W passes through.
- Bus outputs are held stable for the whole BUS state. They return to 0 in IDLE and RESP.

## Timing
- Reset values (asynchronous assert):
  - State = IDLE, so req_ready = 1.
  - All other outputs = 0: rsp_valid, rsp_rdata, rsp_err, bus_req, bus_we, bus_addr, bus_wdata, bus_be.
- Reset mid-transaction: bus_req drops immediately and the in-flight response is discarded. No rsp_valid is produced.
- Bus latency:
  - Accept at cycle T (req_valid & req_ready); bus_req is high from T+1.
  - Zero-wait ack at T+1 gives rsp_valid at T+2.
  - Each wait cycle adds 1.
- Error latency: accept at T, rsp_valid/rsp_err at T+1. bus_req never asserts.
- Throughput: req_ready is low in BUS and RESP, so a new request is accepted no earlier than the cycle after rsp_valid.
- bus_ack while bus_req = 0 is ignored.
- req_* inputs are sampled only at acceptance.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A 16-bit wait counter clears on entry to BUS and increments each BUS cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack, the next state is RESP with rsp_err = 1 and rsp_rdata = 0, and bus_req deasserts.
  - An ack in the same cycle the limit is reached wins: normal response, no error.
- LSU_TIMEOUT_EN undefined: no counter; the LSU waits in BUS indefinitely. TIMEOUT_CYCLES is ignored.

## Test plan
- LW at 0x100, ack at T+1 with bus_rdata = 0xDEADBEEF → bus_be = 1111, bus_addr = 0x100; rsp_valid at T+2 with rdata 0xDEADBEEF, err 0.
- LB at 0x103 and LBU at 0x103, bus_rdata = 0x80123456 → rdata 0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x202, wdata 0x1234ABCD, ack after 3 wait cycles → bus_addr 0x200, be 1100, wdata 0xABCDABCD held stable; rsp_valid 5 cycles after accept, rdata 0.
- LW at 0x101 and load with funct3 011 → rsp_err pulse at T+1, bus_req never high.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack → bus_req high for 4 cycles, then rsp_valid with err 1. Repeat with ack on the 4th cycle → no error.
- Reset driven low during BUS → bus_req drops the same cycle, no rsp_valid; after release, a fresh LW completes normally.
